data_buffer: RTL and testbench

DATA_BUFFER -- requirements
Module: data_buffer

---
 rtl/data_buffer.sv | 102 ++++++++++
 tb/tb_data_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_buffer.sv
// 64x8 show-ahead circular FIFO shared by the AHB and USB sides: one write port
// (either side may write) and one pop port (either side may pop).
module data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       get_rx_data,
    input  logic       store_rx_packet_data,
    input  logic [7:0] rx_packet_data,
    input  logic       get_tx_packet_data,
    output logic [7:0] rx_data,
    output logic [7:0] tx_packet_data,
    output logic [6:0] buffer_occupancy,
    output logic       overflow,
    output logic       underflow
);

    logic [7:0] r_mem [0:DEPTH-1];
    logic [5:0] r_wptr;
    logic [5:0] r_rptr;
    logic [6:0] r_occ;
    logic       r_full;
    logic       r_overflow;
    logic       r_underflow;

    logic       w_wr_req;
    logic       w_pop_req;
    logic       w_empty;
    logic       w_wr_ok;
    logic       w_pop_ok;
    logic [7:0] w_wdata;
    logic [7:0] w_head;
    logic [6:0] w_occ_next;

    // AHB-side byte wins when both sides write in the same cycle.
    assign w_wr_req  = store_tx_data | store_rx_packet_data;
    assign w_wdata   = store_tx_data ? tx_data : rx_packet_data;
    assign w_pop_req = get_rx_data | get_tx_packet_data;
    assign w_empty   = (r_occ == 7'd0);

    // A full buffer still takes a write when a pop frees the head slot this cycle.
    assign w_wr_ok  = w_wr_req & (~r_full | w_pop_req);
    assign w_pop_ok = w_pop_req & ~w_empty;

    always_comb begin
        w_occ_next = r_occ;
        case ({w_wr_ok, w_pop_ok})
            2'b10:   w_occ_next = r_occ + 7'd1;
            2'b01:   w_occ_next = r_occ - 7'd1;
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr      <= 6'd0;
            r_rptr      <= 6'd0;
            r_occ       <= 7'd0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_wptr      <= 6'd0;
            r_rptr      <= 6'd0;
            r_occ       <= 7'd0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 6'd1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 6'd1;
            end
            r_occ       <= w_occ_next;
            r_full      <= (w_occ_next == 7'd64);
            r_overflow  <= w_wr_req & r_full & ~w_pop_req;
            r_underflow <= w_pop_req & w_empty & ~w_wr_req;
        end
    end

    // Storage carries no reset; stale bytes are never visible because the head
    // is masked whenever the occupancy is zero.
    always_ff @(posedge clk) begin
        if (n_rst && !clear && w_wr_ok) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    assign w_head           = w_empty ? 8'h00 : r_mem[r_rptr];
    assign rx_data          = w_head;
    assign tx_packet_data   = w_head;
    assign buffer_occupancy = r_occ;
    assign overflow         = r_overflow;
    assign underflow        = r_underflow;

endmodule

// File: tb/tb_data_buffer.sv
// Directed plus random bench for data_buffer, checked every cycle against a
// queue-based reference model of the FIFO.
module tb_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_rx_data;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] rx_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    data_buffer #(.DEPTH(64)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .rx_data              (rx_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .overflow             (overflow),
        .underflow            (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_occ"}, 32'(buffer_occupancy), 32'(q.size()));
        chk({tag, "_rx"}, 32'(rx_data), 32'(exp_head()));
        chk({tag, "_txp"}, 32'(tx_packet_data), 32'(exp_head()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, "_unf"}, 32'(underflow), 32'(exp_unf));
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1 ns later.
    task automatic step(input string tag, input logic stx, input logic [7:0] txd,
                        input logic srx, input logic [7:0] rxd,
                        input logic grx, input logic gtx, input logic clr);
        int   n0;
        logic wr, pop;
        store_tx_data        = stx;
        tx_data              = txd;
        store_rx_packet_data = srx;
        rx_packet_data       = rxd;
        get_rx_data          = grx;
        get_tx_packet_data   = gtx;
        clear                = clr;
        @(posedge clk);
        wr  = stx | srx;
        pop = grx | gtx;
        n0  = q.size();
        if (clr) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = wr && (n0 == 64) && !pop;
            exp_unf = pop && (n0 == 0) && !wr;
            if (pop && n0 > 0) void'(q.pop_front());
            if (wr && (n0 < 64 || pop)) q.push_back(stx ? txd : rxd);
        end
        #1;
        check_all(tag);
    endtask

    task automatic wr_tx(input string tag, input logic [7:0] d);
        step(tag, 1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_rx(input string tag);
        step(tag, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_rst = 1'b0;
        {clear, store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data} = '0;
        tx_data = 8'h00;
        rx_packet_data = 8'h00;

        // Reset state
        #12;
        check_all("reset");
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Two writes then one pop
        wr_tx("w_a5", 8'hA5);
        wr_tx("w_3c", 8'h3C);
        chk("basic_occ2", 32'(buffer_occupancy), 32'd2);
        chk("basic_head_a5", 32'(rx_data), 32'hA5);
        pop_rx("pop1");
        chk("basic_head_3c", 32'(rx_data), 32'h3C);
        pop_rx("drain");

        // Fill, overflow, drain in order
        for (int i = 0; i < 64; i++) wr_tx("fill", 8'(i));
        chk("full_occ", 32'(buffer_occupancy), 32'd64);
        wr_tx("ovf_wr", 8'hEE);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        idle("ovf_end");
        chk("ovf_gone", 32'(overflow), 32'd0);
        // Full with write and pop together: both accepted, no overflow
        step("full_both", 1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            chk("drain_head", 32'(tx_packet_data), (i < 63) ? 32'(i + 1) : 32'h99);
            step("drain", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("drained_occ", 32'(buffer_occupancy), 32'd0);

        // Underflow, then pop plus write while empty
        pop_rx("unf_pop");
        chk("unf_pulse", 32'(underflow), 32'd1);
        step("empty_both", 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("empty_both_head", 32'(rx_data), 32'h11);
        pop_rx("clean");

        // Both writers: AHB byte wins; both poppers: single pop
        step("dual_wr", 1'b1, 8'h5A, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        step("rx_only", 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        step("dual_pop", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("dual_pop_head", 32'(rx_data), 32'hC3);
        pop_rx("clean2");

        // Pointer wrap
        for (int i = 0; i < 40; i++) wr_tx("wrap_w1", 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) pop_rx("wrap_p");
        for (int i = 0; i < 40; i++) wr_tx("wrap_w2", 8'(8'h80 + i));
        chk("wrap_occ", 32'(buffer_occupancy), 32'd40);
        for (int i = 0; i < 40; i++) begin
            chk("wrap_data", 32'(rx_data), 32'(8'h80 + i));
            pop_rx("wrap_rd");
        end

        // Clear beats a simultaneous write
        for (int i = 0; i < 10; i++) wr_tx("pre_clr", 8'(8'hD0 + i));
        step("clear", 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clear_occ", 32'(buffer_occupancy), 32'd0);
        chk("clear_rx", 32'(rx_data), 32'h00);
        wr_tx("post_clr", 8'h42);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 50), 8'($urandom),
                 1'($urandom_range(0, 99) < 20), 8'($urandom),
                 1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 15),
                 1'($urandom_range(0, 199) == 0));
        end

        // Asynchronous reset mid-stream at occupancy 5
        step("pre_rst_clr", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) wr_tx("pre_rst", 8'(8'h60 + i));
        chk("pre_rst_occ", 32'(buffer_occupancy), 32'd5);
        #2;
        n_rst = 1'b0;
        #1;
        q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        n_rst = 1'b1;
        wr_tx("post_rst", 8'hB7);
        chk("post_rst_head", 32'(rx_data), 32'hB7);
        idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
